// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held while the owner keeps requesting.
// Optional grant timeout compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW      = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic          timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_gnt_idx, w_idx_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] w_pick, w_idx_inc;
  logic [IW:0]   w_cand;
  logic          w_found;
  logic          w_expire;

  if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
    $error("rr_arbiter: parameter out of range");
  end

  // Rotating search starting at r_ptr; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) w_cand = w_cand - (IW+1)'(N);
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IW-1:0];
      end
    end
  end

  assign w_idx_inc = (r_gnt_idx == IW'(N-1)) ? '0 : r_gnt_idx + 1'b1;

`ifdef RR_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout;
  logic        w_revoke;

  assign w_expire = (r_cnt == 16'(MAX_HOLD));
  assign w_revoke = (r_state == S_BUSY) && req[r_gnt_idx] && w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_revoke;
      if (w_state_nxt == S_IDLE)
        r_cnt <= '0;
      else if (r_state == S_IDLE)
        r_cnt <= 16'd1;
      else
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick;
          w_idx_nxt   = w_pick;
        end
      end
      S_BUSY: begin
        // Release and timeout revoke take the same path; pointer moves past the owner.
        if (!req[r_gnt_idx] || w_expire) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_ptr_nxt   = w_idx_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = r_gnt;
    gnt_valid = (r_state == S_BUSY);
    gnt_idx   = r_gnt_idx;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=8, MAX_HOLD=4); honours RR_ARB_TIMEOUT_EN if defined.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  typedef struct {
    string      nm;
    logic [7:0] g;
    logic [2:0] i;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
  endtask

  // Drive req away from the active edge; the response appears after the next posedge.
  task automatic step(input string nm, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] ei, input logic eto);
    @(negedge clk);
    req = r;
    q.push_back('{nm, eg, ei, eto});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".gnt"},     32'(gnt),       32'(e.g));
        chk({e.nm, ".valid"},   32'(gnt_valid), 32'(e.g != 8'h00));
        chk({e.nm, ".idx"},     32'(gnt_idx),   32'(e.i));
        chk({e.nm, ".timeout"}, 32'(timeout),   32'(e.to));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] g;
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    chk("in_reset.gnt",   32'(gnt),       32'h0);
    chk("in_reset.valid", 32'(gnt_valid), 32'h0);
    chk("in_reset.idx",   32'(gnt_idx),   32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) step("idle_zero", 8'h00, 8'h00, 3'd0, 1'b0);

    step("first_grant",  8'h05, 8'h01, 3'd0, 1'b0);
    step("drop0",        8'h04, 8'h00, 3'd0, 1'b0);
    step("grant2",       8'h04, 8'h04, 3'd2, 1'b0);
    step("release2",     8'h00, 8'h00, 3'd0, 1'b0);

    do_reset();
    for (int k = 0; k < 9; k++) begin
      g = 8'h01 << (k % 8);
      step("rr_issue",   8'hFF,       g,     3'(k % 8), 1'b0);
      step("rr_hold",    8'hFF,       g,     3'(k % 8), 1'b0);
      step("rr_release", 8'hFF & ~g,  8'h00, 3'd0,      1'b0);
    end

    step("grant6",       8'h40, 8'h40, 3'd6, 1'b0);
    step("release6",     8'h00, 8'h00, 3'd0, 1'b0);
    step("wrap_to0",     8'h41, 8'h01, 3'd0, 1'b0);
    step("release0",     8'h00, 8'h00, 3'd0, 1'b0);

    step("grant1",       8'h06, 8'h02, 3'd1, 1'b0);
    step("others_ign",   8'hFF, 8'h02, 3'd1, 1'b0);
    step("release1",     8'h00, 8'h00, 3'd0, 1'b0);
    step("dropped_ng",   8'h00, 8'h00, 3'd0, 1'b0);
    step("grant3",       8'h08, 8'h08, 3'd3, 1'b0);
    step("release3",     8'h00, 8'h00, 3'd0, 1'b0);

    do_reset();
`ifdef RR_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) step("to_hold", 8'h09, 8'h01, 3'd0, 1'b0);
    step("to_revoke",    8'h09, 8'h00, 3'd0, 1'b1);
    step("to_next",      8'h09, 8'h08, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) step("to_hold3", 8'h08, 8'h08, 3'd3, 1'b0);
    step("drop_at_max",  8'h00, 8'h00, 3'd0, 1'b0);
`else
    for (int k = 0; k < 8; k++) step("hold_forever", 8'h09, 8'h01, 3'd0, 1'b0);
    step("release_long", 8'h00, 8'h00, 3'd0, 1'b0);
`endif

    do_reset();
    step("grant4",       8'h10, 8'h10, 3'd4, 1'b0);
    @(posedge clk);
    #4;
    chk("pre_async.gnt", 32'(gnt), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("async_rst.gnt",     32'(gnt),       32'h0);
    chk("async_rst.valid",   32'(gnt_valid), 32'h0);
    chk("async_rst.idx",     32'(gnt_idx),   32'h0);
    chk("async_rst.timeout", 32'(timeout),   32'h0);
    req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back('{"post_reset_first", 8'h01, 3'd0, 1'b0});
    step("post_reset_rel", 8'h00, 8'h00, 3'd0, 1'b0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #5;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 8: number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 16: maximum cycles a grant is held; used only when RR_ARB_TIMEOUT_EN is defined; legal range 1..65535.
REQ-003 Derived width IW = max(1, clog2(N)) SHALL size gnt_idx and the internal pointer.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N  request vector; bit i = requester i wants the resource; level-sensitive.
REQ-007 gnt  output  N  registered one-hot grant; all-zero when no grant.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 gnt_idx  output  IW  binary index of the set gnt bit; 0 when gnt_valid is low.
REQ-010 timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without RR_ARB_TIMEOUT_EN.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 The block SHALL keep a priority pointer ptr (IW bits, values 0..N-1) naming the highest-priority requester.
REQ-013 IDLE, req all-zero: SHALL remain in IDLE; outputs stay zero.
REQ-014 IDLE, req non-zero: SHALL select the first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap at N), and at the next edge assert gnt/gnt_idx/gnt_valid for it and enter BUSY; latency is one cycle.
REQ-015 BUSY: SHALL hold gnt unchanged while req[gnt_idx] is sampled high; other req bits SHALL be ignored.
REQ-016 BUSY, req[gnt_idx] sampled low: at the next edge gnt, gnt_valid and gnt_idx SHALL clear, ptr SHALL become (gnt_idx+1) mod N, and the FSM SHALL enter IDLE.
REQ-017 Every grant SHALL be followed by at least one IDLE cycle with gnt all-zero; back-to-back grants SHALL NOT occur.
REQ-018 ptr SHALL change only on grant release or revocation; it SHALL NOT change when a grant is issued.
REQ-019 gnt SHALL never have more than one bit set.
REQ-020 A requester whose req drops in IDLE before being granted SHALL NOT be granted.

Reset
REQ-021 rst_n low SHALL immediately, without a clock edge, force state=IDLE, ptr=0, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 and hold count=0.
REQ-022 Reset asserted mid-grant SHALL abort the grant; after deassertion the first arbitration SHALL use ptr=0.
REQ-023 The first rising clk edge after rst_n rises SHALL be a normal arbitration edge.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN SHALL compile in the grant-timeout feature.
REQ-025 With RR_ARB_TIMEOUT_EN: a hold counter SHALL load 1 when a grant is issued and increment each BUSY cycle; gnt SHALL be high for at most MAX_HOLD cycles.
REQ-026 With RR_ARB_TIMEOUT_EN: when the counter equals MAX_HOLD and req[gnt_idx] is still high, the next edge SHALL clear the grant, set ptr=(gnt_idx+1) mod N, enter IDLE and raise timeout for exactly that one cycle.
REQ-027 With RR_ARB_TIMEOUT_EN: if req[gnt_idx] drops in the same cycle the counter reaches MAX_HOLD, the release is normal and timeout SHALL stay 0.
REQ-028 Without RR_ARB_TIMEOUT_EN: no hold counter SHALL exist, grants SHALL be held indefinitely, and timeout SHALL be tied to 0.

Verification (N=8, MAX_HOLD=4)
REQ-029 Reset, req=8'h00 for 10 cycles -> gnt=8'h00, gnt_valid=0 throughout.
REQ-030 From reset req=8'b0000_0101 -> next cycle gnt=8'h01, gnt_idx=0; drop req[0] -> gnt=8'h00 one cycle, then gnt=8'h04, gnt_idx=2.
REQ-031 req=8'hFF, each granted requester drops req for one cycle after 2 grant cycles -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-032 ptr=7 (after releasing grant 6), req=8'b0100_0001 -> gnt=8'h01 (wrap), not 8'h40.
REQ-033 RR_ARB_TIMEOUT_EN, req=8'b0000_1001 held from IDLE with ptr=0 -> gnt=8'h01 for exactly 4 cycles, then gnt=8'h00 with timeout=1 for one cycle, then gnt=8'h08.
REQ-034 rst_n pulled low between clock edges while gnt=8'h10 -> gnt, gnt_valid, gnt_idx zero before the next edge; after release with req=8'hFF -> first grant 8'h01.
